name_sequencer: RTL

//   Upstream driver for the 4-input letter/segment decoder. Steps a 4-bit letter

---
 rtl/name_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/name_sequencer.sv
// Letter-index sequencer feeding the 4-input decoder: prescaled auto-advance or single-step.
// Optional display blink gated by NAME_SEQ_BLINK_EN (blank tied low when undefined).
module name_sequencer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned SEQ_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic step,
    input  logic dir,
    output logic x0,
    output logic x1,
    output logic x2,
    output logic x3,
    output logic tick,
    output logic blank
);

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic             r_step_q;
    logic             r_tick;
    logic             w_term;
    logic             w_step_re;
    logic             w_adv;
    logic [3:0]       w_idx_nxt;

    assign w_term    = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign w_step_re = step & ~r_step_q;
    assign w_adv     = (run & w_term) | (~run & w_step_re);

    always_comb begin
        w_idx_nxt = r_idx;
        if (dir == 1'b0) begin
            w_idx_nxt = (r_idx == 4'(SEQ_LEN - 1)) ? 4'd0 : r_idx + 4'd1;
        end else begin
            w_idx_nxt = (r_idx == 4'd0) ? 4'(SEQ_LEN - 1) : r_idx - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_step_q <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_step_q <= step;
            if (run) begin
                if (w_term) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + CNT_W'(1);
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
            if (w_adv) begin
                r_idx <= w_idx_nxt;
            end
        end
    end

`ifdef NAME_SEQ_BLINK_EN
    logic r_blank;

    // Toggles on the same edge as the index update, so blink runs at half the step rate.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_blank <= 1'b0;
        end else if (w_term) begin
            r_blank <= ~r_blank;
        end
    end

    assign blank = r_blank;
`else
    assign blank = 1'b0;
`endif

    assign x0   = r_idx[3];
    assign x1   = r_idx[2];
    assign x2   = r_idx[1];
    assign x3   = r_idx[0];
    assign tick = r_tick;

endmodule
